blood_sample_receiver: RTL

Serial front end of the health-monitoring datapath: deserializes framed blood-sensor readings from a 1-bit sensor link and presents each reading as a parallel `bloodPH`/`bloodType` pair with a valid/ready handshake. Its outputs feed the blood abnormality detection logic directly. It checks parity, framing and inter-bit timeout, and flags dropped samples.

---
 rtl/blood_sample_receiver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/blood_sample_receiver.sv
// Serial blood-sensor frame receiver: 10-bit strobed frames in, parallel pH/type sample out.
// Optional BLOOD_PH_RANGE_CHECK_EN rejects the reserved pH code 4'hF as a frame error.
module blood_sample_receiver #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensorStrobe,
    input  logic       sensorBit,
    input  logic       sampleReady,
    output logic [3:0] bloodPH,
    output logic [2:0] bloodType,
    output logic       sampleValid,
    output logic       frameError,
    output logic       overrun
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_bitcnt;
    logic [6:0]      r_shift;
    logic            r_par;
    logic [TW-1:0]   r_tmo;
    logic [3:0]      r_ph;
    logic [2:0]      r_type;
    logic            r_valid;
    logic            r_err;
    logic            r_ovr;

    logic            w_timeout;
    logic            w_frame_done;
    logic            w_ph_ok;
    logic            w_good;
    logic            w_bad;
    logic            w_free;
    logic            w_load;

    function automatic logic even_par7(input logic [6:0] d);
        return ^d;
    endfunction

    assign w_timeout    = (r_state != S_IDLE) && (r_tmo == TMO_MAX);
    assign w_frame_done = (r_state == S_STOP) && sensorStrobe && !w_timeout;
`ifdef BLOOD_PH_RANGE_CHECK_EN
    assign w_ph_ok      = (r_shift[6:3] != 4'hF);
`else
    assign w_ph_ok      = 1'b1;
`endif
    assign w_good       = w_frame_done && !sensorBit && (r_par == even_par7(r_shift)) && w_ph_ok;
    assign w_bad        = w_frame_done && !w_good;
    assign w_free       = !r_valid || sampleReady;
    assign w_load       = w_good && w_free;

    // Next-state: a timeout abandons the frame even if a strobe arrives that cycle
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_IDLE;
        end else if (sensorStrobe) begin
            case (r_state)
                S_IDLE:   if (sensorBit) w_next = S_DATA; else w_next = S_IDLE;
                S_DATA:   if (r_bitcnt == 3'd6) w_next = S_PARITY; else w_next = S_DATA;
                S_PARITY: w_next = S_STOP;
                S_STOP:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end else begin
            w_next = r_state;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Deserializer: bit counter, shift register, parity capture, inter-bit timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 7'd0;
            r_par    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            if (sensorStrobe && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_shift  <= {r_shift[5:0], sensorBit};
                    end
                    S_PARITY: r_par <= sensorBit;
                    default:  r_bitcnt <= r_bitcnt;
                endcase
            end
            if ((r_state == S_IDLE) || w_timeout || sensorStrobe) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // Output sample holding register and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph    <= 4'h0;
            r_type  <= 3'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_err <= w_bad || w_timeout;
            r_ovr <= w_good && !w_free;
            if (w_load) begin
                r_ph    <= r_shift[6:3];
                r_type  <= r_shift[2:0];
                r_valid <= 1'b1;
            end else if (r_valid && sampleReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bloodPH     = r_ph;
    assign bloodType   = r_type;
    assign sampleValid = r_valid;
    assign frameError  = r_err;
    assign overrun     = r_ovr;

endmodule
